timer_cmd_tx: RTL and testbench
===============================

Name: timer_cmd_tx

Overview:
- Transmit-side companion to the one-hot timer receiver FSM.
- Accepts a 4-bit delay command over a valid/ready handshake and serialises it onto the receiver's `d` line: optional zero guard bits, start pattern 1101, then delay bits MSB first.
- Then waits for the receiver's `done` and returns a single-cycle `ack`.
- A watchdog aborts the exchange if `done` never arrives.

Parameters:
- GUARD_BITS, 1, number of d=0 cycles sent before the start pattern (legal 0..15); flushes any partial pattern match in the receiver.
- TIMEOUT_CYCLES, 20000, maximum cycles spent in WAIT_DONE before abort; 0 disables the watchdog. Legal 0..65535.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_delay  input  4  delay value to transmit
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready at a clock edge
- d  output  1  serial line to receiver
- done  input  1  receiver "timer finished" indication
- ack  output  1  one-cycle acknowledge to receiver
- busy  output  1  high in every state except IDLE
- timeout  output  1  one-cycle pulse on watchdog abort
- proto_err  output  1  one-cycle pulse when done=1 is sampled in GUARD/PATTERN/DATA states

Behaviour:
- Reset (synchronous): state=IDLE, d=0, ack=0, busy=0, timeout=0, proto_err=0, counters=0, delay latch=0. Reset mid-exchange aborts immediately; no ack or timeout is issued.
- Moore FSM: all outputs are decoded from registered state (plus registered one-cycle pulse flags). No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: d=0. On handshake, latch cmd_delay and go to GUARD (or P0 if GUARD_BITS=0). A handshake occurs only in IDLE.
  - GUARD: d=0 for exactly GUARD_BITS cycles, counted by a guard counter, then P0.
  - P0,P1,P2,P3: d = 1,1,0,1 respectively, one cycle each.
  - D3,D2,D1,D0: d = latched delay bit 3,2,1,0, one cycle each.
  - WAIT_DONE: d=0, watchdog counter increments each cycle.
    - If done=1 is sampled, go to ACK.
    - Otherwise, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1, go to IDLE and pulse timeout on the next cycle.
    - done has priority over timeout when both occur in the same cycle.
  - ACK: d=0, ack=1 for exactly one cycle, then IDLE.
- Timing: handshake at edge T; first guard bit is driven in cycle T+1. The pattern starts at T+1+GUARD_BITS. D0 is driven at T+8+GUARD_BITS. WAIT_DONE is entered the cycle after D0.
- done is ignored in IDLE and ACK.
- done sampled high in GUARD/P*/D* pulses proto_err for one cycle and does not alter the sequence.
- The watchdog counter is 16 bits wide, cleared on WAIT_DONE entry, and saturating; it never wraps.
- busy=1 from T+1 through the ACK cycle or the final WAIT_DONE cycle. cmd_ready returns high in the cycle after ACK or abort.
- Back-to-back: cmd_valid held high is accepted on the first IDLE cycle; the minimum spacing between accepts is GUARD_BITS+10 cycles.
- The latched delay is stable for the whole exchange. cmd_delay changes after acceptance have no effect.

Test Plan:
- Reset then cmd_delay=4'b1010, GUARD_BITS=1 -> d over cycles T+1..T+9 = 0,1,1,0,1,1,0,1,0; busy=1 from T+1; cmd_ready=0 until after ACK.
- Continuing, done raised 5 cycles into WAIT_DONE -> ack=1 exactly one cycle after done is sampled, then cmd_ready=1 and busy=0 the next cycle.
- TIMEOUT_CYCLES=8, done never asserted -> timeout pulses once, 8 cycles after WAIT_DONE entry; no ack; return to IDLE.
- done=1 in the same cycle the watchdog expires -> ack issued, timeout stays 0.
- done=1 during P2 -> proto_err one-cycle pulse; d sequence unchanged; exchange completes normally.
- Reset asserted during D1 -> next cycle d=0, busy=0, cmd_ready=1, no ack/timeout. A new command 4'b0001 with GUARD_BITS=0 emits 1,1,0,1,0,0,0,1 starting at T+1.

Source files
------------

// File: rtl/timer_cmd_tx.sv
// ---------------------------------------------------------------------------
// timer_cmd_tx
//
// Transmit-side companion to the one-hot timer receiver. It takes a 4-bit
// delay command and serialises it onto the receiver's d line as:
//   GUARD_BITS zero cycles, start pattern 1101, delay bits MSB first.
// It then waits for the receiver's done, answers with a one-cycle ack and
// returns to IDLE. A watchdog abandons the exchange if done never arrives.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so at most one
// command is in flight. cmd_valid may be held high: the command is taken on
// the first IDLE cycle.
//
// Ports:
//   clk        in   clock, everything on the rising edge
//   reset      in   synchronous active-high reset
//   cmd_valid  in   command request
//   cmd_delay  in   [3:0] delay value to transmit
//   cmd_ready  out  high only in IDLE
//   d          out  serial line to the receiver
//   done       in   receiver "timer finished" indication
//   ack        out  one-cycle acknowledge
//   busy       out  high in every state except IDLE
//   timeout    out  one-cycle pulse on watchdog abort
//   proto_err  out  one-cycle pulse when done is seen while transmitting
//   dbg_state  out  [3:0] current FSM state encoding
//
// Parameters:
//   GUARD_BITS      0..15, zero cycles sent before the start pattern
//   TIMEOUT_CYCLES  0..65535, WAIT_DONE cycle limit, 0 disables the watchdog
// ---------------------------------------------------------------------------
module timer_cmd_tx #(
  parameter int unsigned GUARD_BITS     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_delay,
  output logic       cmd_ready,
  output logic       d,
  input  logic       done,
  output logic       ack,
  output logic       busy,
  output logic       timeout,
  output logic       proto_err,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GUARD = 4'd1,
    S_P0    = 4'd2,
    S_P1    = 4'd3,
    S_P2    = 4'd4,
    S_P3    = 4'd5,
    S_D3    = 4'd6,
    S_D2    = 4'd7,
    S_D1    = 4'd8,
    S_D0    = 4'd9,
    S_WAIT  = 4'd10,
    S_ACK   = 4'd11
  } state_t;

  // Last guard count / last watchdog count before leaving the state.
  localparam logic [3:0]  GUARD_LAST = 4'(GUARD_BITS == 0 ? 0 : GUARD_BITS - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [3:0]  delay_q;
  logic [3:0]  guard_cnt_q;
  logic [15:0] wd_cnt_q;
  logic        d_q, d_d;
  logic        busy_q, ready_q, ack_q;
  logic        timeout_q, timeout_d;
  logic        proto_err_q, proto_err_d;

  // Next-state logic. Pulse flags are computed here and registered, so no
  // input reaches an output combinationally.
  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = (GUARD_BITS == 0) ? S_P0 : S_GUARD;
      end
      S_GUARD: begin
        proto_err_d = done;
        if (guard_cnt_q == GUARD_LAST) state_d = S_P0;
      end
      S_P0: begin proto_err_d = done; state_d = S_P1; end
      S_P1: begin proto_err_d = done; state_d = S_P2; end
      S_P2: begin proto_err_d = done; state_d = S_P3; end
      S_P3: begin proto_err_d = done; state_d = S_D3; end
      S_D3: begin proto_err_d = done; state_d = S_D2; end
      S_D2: begin proto_err_d = done; state_d = S_D1; end
      S_D1: begin proto_err_d = done; state_d = S_D0; end
      S_D0: begin proto_err_d = done; state_d = S_WAIT; end
      S_WAIT: begin
        // done wins over a watchdog expiry in the same cycle.
        if (done) begin
          state_d = S_ACK;
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serial data for the state being entered; registered with the state.
  // D3..D0 are only entered after P3, by which time delay_q is latched.
  always_comb begin
    d_d = 1'b0;
    case (state_d)
      S_P0, S_P1, S_P3: d_d = 1'b1;
      S_D3:             d_d = delay_q[3];
      S_D2:             d_d = delay_q[2];
      S_D1:             d_d = delay_q[1];
      S_D0:             d_d = delay_q[0];
      default:          d_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      delay_q     <= 4'd0;
      guard_cnt_q <= 4'd0;
      wd_cnt_q    <= 16'd0;
      d_q         <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && cmd_valid) delay_q <= cmd_delay;

      if ((state_q == S_GUARD) && (state_d == S_GUARD)) guard_cnt_q <= guard_cnt_q + 4'd1;
      else                                              guard_cnt_q <= 4'd0;

      // Zero on WAIT_DONE entry, saturating increment while waiting.
      if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
        if (wd_cnt_q != 16'hFFFF) wd_cnt_q <= wd_cnt_q + 16'd1;
      end else begin
        wd_cnt_q <= 16'd0;
      end

      d_q         <= d_d;
      busy_q      <= (state_d != S_IDLE);
      ready_q     <= (state_d == S_IDLE);
      ack_q       <= (state_d == S_ACK);
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign d         = d_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_timer_cmd_tx
//
// Two instances: dut_g1 (GUARD_BITS=1, TIMEOUT_CYCLES=8) and dut_g0
// (GUARD_BITS=0, watchdog disabled). They share stimulus inputs but have
// separate resets; the instance not under test is held in reset.
// Observed outputs are packed as {d, busy, cmd_ready, ack, timeout, proto_err}.
// ---------------------------------------------------------------------------
module tb_timer_cmd_tx;

  localparam int G1 = 1, TO1 = 8;
  localparam int G2 = 0, TO2 = 0;
  localparam logic [5:0] IDLE_V = 6'b001000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, reset2;
  logic       cmd_valid, done;
  logic [3:0] cmd_delay;

  logic rdy1, d1, ack1, busy1, to1, pe1;
  logic rdy2, d2, ack2, busy2, to2, pe2;
  logic [3:0] dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  timer_cmd_tx #(.GUARD_BITS(G1), .TIMEOUT_CYCLES(TO1)) dut_g1 (
    .clk(clk), .reset(reset1), .cmd_valid(cmd_valid), .cmd_delay(cmd_delay),
    .cmd_ready(rdy1), .d(d1), .done(done), .ack(ack1), .busy(busy1),
    .timeout(to1), .proto_err(pe1), .dbg_state(dbg1)
  );

  timer_cmd_tx #(.GUARD_BITS(G2), .TIMEOUT_CYCLES(TO2)) dut_g0 (
    .clk(clk), .reset(reset2), .cmd_valid(cmd_valid), .cmd_delay(cmd_delay),
    .cmd_ready(rdy2), .d(d2), .done(done), .ack(ack2), .busy(busy2),
    .timeout(to2), .proto_err(pe2), .dbg_state(dbg2)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs(input int sel);
    return (sel == 0) ? {d1, busy1, rdy1, ack1, to1, pe1}
                      : {d2, busy2, rdy2, ack2, to2, pe2};
  endfunction

  // Reference: bit i of a frame = guard zeros, then 1101, then delay MSB first.
  function automatic logic ref_d(input int g, input logic [3:0] dly, input int i);
    logic [3:0] pat;
    pat = 4'b1101;
    if (i < g)     return 1'b0;
    if (i < g + 4) return pat[3 - (i - g)];
    return dly[7 - (i - g)];
  endfunction

  // One complete exchange, starting in an IDLE cycle and ending in the first
  // IDLE cycle afterwards. pe_idx: frame index where done is pulsed (-1 none).
  // done_at: WAIT_DONE cycle index where done is pulsed (-1 never).
  task automatic exchange(input int sel, input logic [3:0] dly, input int pe_idx,
                          input int done_at, input string name);
    int g, to, n, wait_len;
    bit ack_case;
    logic [5:0] exp;
    g  = (sel == 0) ? G1 : G2;
    to = (sel == 0) ? TO1 : TO2;
    n  = g + 8;
    ack_case = (done_at >= 0) && ((to == 0) || (done_at <= to - 1));
    wait_len = ack_case ? done_at + 1 : to;

    cmd_valid = 1'b1;
    cmd_delay = dly;
    tick();
    for (int i = 0; i < n; i++) begin
      exp = {ref_d(g, dly, i), 1'b1, 1'b0, 1'b0, 1'b0, (pe_idx >= 0 && i == pe_idx + 1)};
      checks++;
      if (obs(sel) !== exp) begin
        errors++;
        $display("FAIL %s frame[%0d]: got %b expected %b", name, i, obs(sel), exp);
      end
      cmd_valid = 1'($urandom % 2);
      cmd_delay = 4'($urandom);
      done      = (i == pe_idx);
      tick();
    end
    for (int j = 0; j < wait_len; j++) begin
      exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (j == 0 && pe_idx == n - 1)};
      checks++;
      if (obs(sel) !== exp) begin
        errors++;
        $display("FAIL %s wait[%0d]: got %b expected %b", name, j, obs(sel), exp);
      end
      done = (j == done_at);
      tick();
    end
    if (ack_case) begin
      checks++;
      if (obs(sel) !== 6'b010100) begin
        errors++;
        $display("FAIL %s ack_cycle: got %b expected %b", name, obs(sel), 6'b010100);
      end
      done = 1'($urandom % 2);  // ignored in ACK
      tick();
      checks++;
      if (obs(sel) !== IDLE_V) begin
        errors++;
        $display("FAIL %s after_ack: got %b expected %b", name, obs(sel), IDLE_V);
      end
    end else begin
      checks++;
      if (obs(sel) !== 6'b001010) begin
        errors++;
        $display("FAIL %s timeout_cycle: got %b expected %b", name, obs(sel), 6'b001010);
      end
    end
    done      = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int sel, input int cnt, input string name);
    for (int k = 0; k < cnt; k++) begin
      done      = 1'($urandom % 2);  // ignored in IDLE
      cmd_delay = 4'($urandom);
      tick();
      checks++;
      if (obs(sel) !== IDLE_V) begin
        errors++;
        $display("FAIL %s idle[%0d]: got %b expected %b", name, k, obs(sel), IDLE_V);
      end
    end
    done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset1 = 1'b1; reset2 = 1'b1;
    cmd_valid = 1'b1; cmd_delay = 4'hF; done = 1'b1;
    tick(); tick();
    checks++;
    if (obs(0) !== IDLE_V) begin
      errors++;
      $display("FAIL reset_g1: got %b expected %b", obs(0), IDLE_V);
    end
    checks++;
    if (obs(1) !== IDLE_V) begin
      errors++;
      $display("FAIL reset_g0: got %b expected %b", obs(1), IDLE_V);
    end
    cmd_valid = 1'b0; done = 1'b0;
    reset1 = 1'b0;
    idle_cycles(0, 2, "post_reset");
  endtask

  task automatic test_basic();
    exchange(0, 4'b1010, -1, 5, "basic");
    idle_cycles(0, 2, "basic");
  endtask

  task automatic test_timeout();
    exchange(0, 4'($urandom), -1, -1, "timeout");
    idle_cycles(0, 2, "timeout");
  endtask

  task automatic test_done_at_expiry();
    exchange(0, 4'($urandom), -1, TO1 - 1, "done_at_expiry");
    idle_cycles(0, 1, "done_at_expiry");
  endtask

  task automatic test_proto_err();
    // P2 is frame index GUARD_BITS+2.
    exchange(0, 4'b0110, G1 + 2, 3, "proto_err_p2");
    exchange(0, 4'b1001, G1 + 7, 1, "proto_err_d0");
    idle_cycles(0, 1, "proto_err");
  endtask

  task automatic test_back_to_back();
    exchange(0, 4'b0011, -1, 0, "b2b_a");
    exchange(0, 4'b1100, -1, 2, "b2b_b");
    exchange(0, 4'b0101, -1, -1, "b2b_c");
    exchange(0, 4'b1111, -1, 4, "b2b_d");
    idle_cycles(0, 1, "b2b");
  endtask

  task automatic test_random();
    logic [3:0] dly;
    int pe, da;
    for (int k = 0; k < 10; k++) begin
      dly = 4'($urandom);
      pe  = ($urandom % 3 == 0) ? int'($urandom_range(0, G1 + 7)) : -1;
      da  = ($urandom % 4 == 0) ? -1 : int'($urandom_range(0, 10));
      exchange(0, dly, pe, da, "random");
      if ($urandom % 2 == 1) idle_cycles(0, int'($urandom_range(1, 3)), "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] dly;
    logic [5:0] exp;
    dly = 4'($urandom);
    cmd_valid = 1'b1;
    cmd_delay = dly;
    tick();
    cmd_valid = 1'b0;
    // Run through D1 (frame index GUARD_BITS+6), then reset.
    for (int i = 0; i <= G1 + 6; i++) begin
      exp = {ref_d(G1, dly, i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs(0) !== exp) begin
        errors++;
        $display("FAIL reset_mid frame[%0d]: got %b expected %b", i, obs(0), exp);
      end
      if (i < G1 + 6) tick();
    end
    reset1 = 1'b1;
    tick();
    checks++;
    if (obs(0) !== IDLE_V) begin
      errors++;
      $display("FAIL reset_mid after_reset: got %b expected %b", obs(0), IDLE_V);
    end
    reset1 = 1'b0;
    idle_cycles(0, 10, "reset_mid");
  endtask

  task automatic test_guard0();
    reset1 = 1'b1;
    reset2 = 1'b0;
    tick();
    checks++;
    if (obs(1) !== IDLE_V) begin
      errors++;
      $display("FAIL guard0 idle: got %b expected %b", obs(1), IDLE_V);
    end
    exchange(1, 4'b0001, -1, 25, "guard0_0001");
    exchange(1, 4'($urandom), 2, 0, "guard0_proto");
    exchange(1, 4'($urandom), -1, 40, "guard0_long_wait");
    idle_cycles(1, 2, "guard0");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset1 = 1'b1; reset2 = 1'b1;
    cmd_valid = 1'b0; cmd_delay = 4'd0; done = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_done_at_expiry();
    test_proto_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_guard0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got expired expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
